serial_sub16: RTL and testbench

SERIAL_SUB16 -- requirements
Module: serial_sub16

---
 rtl/serial_sub16_pkg.sv | 13 +
 rtl/serial_sub16_bit_cell.sv | 18 +
 rtl/serial_sub16.sv | 97 +++++++++
 tb/tb_serial_sub16.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub16_pkg.sv
// Shared constants and FSM state type for the bit-serial subtractor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_sub16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_sub16_bit_cell.sv
// Full-adder cell with inverted b input: one bit of a + ~b + cin.
// Latency: combinational.
// Backpressure: none.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic diff,
  output logic cout
);

  logic b_n;

  assign b_n  = ~b;
  assign diff = a ^ b_n ^ cin;
  assign cout = (a & b_n) | (a & cin) | (b_n & cin);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial LSB-first subtractor d = a - b - b_in; optional ovf port via SERIAL_SUB_OVF_EN.
// Latency: start accepted at edge E0 -> done/d valid in the cycle after edge E0+WIDTH.
// Backpressure: start is ignored while busy=1; nothing is queued.
module serial_sub16
  import serial_sub16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   d_sr;
  logic               carry;
  logic               diff_bit;
  logic               carry_nxt;

  sub_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .diff (diff_bit),
    .cout (carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= ~b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_nxt;
          d_sr  <= {diff_bit, d_sr[WIDTH-2:1]};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Last bit: the shift registers now hold the operand MSBs.
            d     <= {diff_bit, d_sr};
            b_out <= ~carry_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_sr[0] != b_sr[0]) && (diff_bit != a_sr[0]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: expected results queued at acceptance, compared at done.
module tb_serial_sub16;
  import serial_sub16_pkg::*;

  localparam int W = WIDTH_DEF;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t sb_q[$];
  exp_t held   = '0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   m_cnt   = 0;
  logic m_done  = 1'b0;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t       e;
    logic [W:0] r;
    r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d  = r[W-1:0];
    e.bo = r[W];
    e.ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  // Reference timing model at each rising edge, output comparison at each falling edge.
  always begin
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_cnt = 0;
      sb_q.delete();
      held = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end else if (start) begin
      m_cnt = W;
      sb_q.push_back(model_sub(a, b, b_in));
    end
    @(negedge clk);
    check_val("busy", 32'(busy), 32'(m_cnt != 0));
    check_val("done", 32'(done), 32'(m_done));
    if (done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
      else held = sb_q.pop_front();
    end
    check_val("d", 32'(d), 32'(held.d));
    check_val("b_out", 32'(b_out), 32'(held.bo));
`ifdef SERIAL_SUB_OVF_EN
    check_val("ovf", 32'(ovf), 32'(held.ov));
`endif
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_cnt == 0 && sb_q.size() == 0) return;
    end
    check_val("timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    @(negedge clk);
    a     = av;
    b     = bv;
    b_in  = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    b_in  = ~bi;
    wait_idle();
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(16'h0005, 16'h0003, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);

    // Second start mid-run must be ignored.
    d0 = n_done;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 16'h0001; b = 16'h0002; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check_val("ignored_start_dones", 32'(n_done - d0), 32'd1);

    // Reset mid-operation aborts with no done.
    d0 = n_done;
    @(negedge clk);
    a = 16'h4444; b = 16'h0101; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    check_val("reset_abort_dones", 32'(n_done - d0), 32'd0);
    run_op(16'hFFFF, 16'h0001, 1'b0);

    // Start held high: back-to-back operations, one every W+1 cycles.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3 * (W + 1); i++) begin
      a    = W'($urandom);
      b    = W'($urandom);
      b_in = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    check_val("b2b_dones", 32'(n_done - d0), 32'd3);

    for (int i = 0; i < 8; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
